// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the MIPS pipeline front-end
package cpu_pkg;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry falling-edge FIFO with flush, count and head view
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop;
    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];
    // pointer and occupancy tracking; flush beats any same-edge push or pop
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !do_pop && count == (AW+1)'(DEPTH)));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
    // entry storage, no reset needed since count gates visibility
    always_ff @(negedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC, imem request credit, redirect and halt handling
module instr_fetch_queue import cpu_pkg::*; #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic        halted
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   fetch_pc, inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    fetch_entry_t  head, din;
    assign imem_req  = !halted && !redirect &&
                       ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc >> 2;
    assign out_valid = count != '0;
    assign out_instr = out_valid ? head.instr : NOP_WORD;
    assign out_pc4   = out_valid ? head.pc4 : 32'h0;
    assign din       = '{instr: imem_rdata, pc4: inflight_pc + 32'd4};
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight && !redirect),
        .pop   (out_valid && out_ready),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );
    // fetch PC, outstanding-read tracking and halt flag; redirect wins
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            halted      <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'd3;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (inflight && imem_rdata == HALT_WORD) halted <= 1'b1;
        end
    end
endmodule
